instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width of the PC.
REQ-002 Parameter RESET_PC, default 64'h0, byte address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 stall  input  1  1 = consumer cannot accept an instruction this cycle.
REQ-006 br_taken  input  1  1-cycle pulse: redirect fetch to br_target.
REQ-007 br_target  input  ADDR_W  redirect byte address.
REQ-008 mem_req_valid  output  1  word-read request to instruction memory.
REQ-009 mem_req_idx  output  ADDR_W-2  word index of the request, equal to the byte PC shifted right by 2.
REQ-010 mem_req_ready  input  1  memory accepts the request when valid and ready are both 1.
REQ-011 mem_resp_valid  input  1  1-cycle pulse: mem_resp_data is valid.
REQ-012 mem_resp_data  input  32  instruction word returned.
REQ-013 instr_valid  output  1  instr and instr_pc are valid.
REQ-014 instr  output  32  fetched instruction.
REQ-015 instr_pc  output  ADDR_W  byte address of instr.
REQ-016 misalign  output  1  sticky fault: a redirect had br_target[1:0] != 0.

Function
REQ-017 States SHALL be REQ, WAIT, HOLD and FAULT.
- REQ: assert mem_req_valid; on handshake go to WAIT.
- WAIT: await mem_resp_valid.
- HOLD: instr_valid=1 while stall=1.
- FAULT: absorbing; left only by reset.
REQ-018 mem_req_idx SHALL equal pc[ADDR_W-1:2] combinationally; pc[1:0] SHALL always be 2'b00.
REQ-019 At most one request SHALL be outstanding.
REQ-020 In WAIT, on mem_resp_valid:
- instr_valid=1 for that cycle, instr=mem_resp_data, instr_pc=pc.
- If stall=0: pc <= pc+4 and go to REQ.
- If stall=1: capture instr/instr_pc and go to HOLD.
REQ-021 In HOLD, when stall falls to 0: instr_valid=1 for that final cycle, pc <= pc+4, go to REQ.
REQ-022 pc+4 SHALL wrap modulo 2^ADDR_W without error.
REQ-023 br_taken with br_target[1:0]==0, in any non-FAULT state:
- pc <= br_target.
- Next state is REQ.
- Any held instruction is dropped.
- If in WAIT, a squash flag is set; the next mem_resp_valid is discarded (no instr_valid) before the new request is issued.
REQ-024 br_taken with br_target[1:0]!=0:
- misalign <= 1, go to FAULT.
- In FAULT, mem_req_valid=0 and instr_valid=0.
REQ-025 br_taken SHALL have priority over a same-cycle mem_resp_valid: that response produces no instr_valid.
REQ-026 mem_req_valid SHALL stay asserted, with mem_req_idx stable, until the handshake, unless a redirect changes pc.
REQ-027 mem_resp_valid arriving in REQ, HOLD or FAULT SHALL be ignored.

Reset
REQ-028 While reset=0, regardless of clk:
- pc=RESET_PC, state=REQ, squash=0.
- Outputs instr_valid=0, misalign=0, instr=0, instr_pc=0.
REQ-029 mem_req_valid SHALL be 0 during reset and SHALL assert on the first posedge after reset deasserts.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request; the first response after reset release SHALL be ignored unless it answers a post-reset request.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum type, INSTR_W=32 and the PC increment constant 4.
REQ-032 One sub-module SHALL be instantiated: shift_right_2, a combinational byte-address to word-index converter producing mem_req_idx.

Verification
REQ-033 Reset release, memory always ready, 1-cycle response -> requests idx 0,1,2; instr_pc 0,4,8; instr_valid every 2nd cycle.
REQ-034 Response returns while stall=1 for 3 cycles -> instr held stable with instr_valid=1; no new request until stall falls; pc then advances by 4.
REQ-035 br_taken to 64'h100 while in WAIT -> pending response dropped; next request idx=64'h40; next instr_pc=64'h100.
REQ-036 br_taken to 64'h102 -> misalign=1 and mem_req_valid=0 permanently; reset clears both.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> next request idx=0, instr_pc=0.
REQ-038 Reset asserted mid-WAIT, then released -> outputs return to reset values and the first request is idx=RESET_PC>>2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_FAULT
   } fetch_state_e;

   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus: one word-read request channel and one response channel.
interface instr_fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 64
);

   logic               mem_req_valid;
   logic [ADDR_W-3:0]  mem_req_idx;
   logic               mem_req_ready;
   logic               mem_resp_valid;
   logic [INSTR_W-1:0] mem_resp_data;

   modport master (
      output mem_req_valid,
      output mem_req_idx,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_idx,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_data
   );

endinterface

// File: rtl/shift_right_2.sv
// Byte address to 32-bit word index; the two byte-offset bits are dropped.
module shift_right_2 #(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ADDR_W-3:0] o_idx
);

   assign o_idx = (ADDR_W-2)'(i_addr >> 2);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher with stall hold, branch redirect,
// squash of in-flight responses and a sticky misaligned-target fault.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                br_taken,
   input  logic [ADDR_W-1:0]   br_target,
   instr_fetch_unit_if.master  mem,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                misalign
);

   fetch_state_e       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_squash;
   logic               r_live;
   logic               r_misalign;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;

   logic               w_req_valid;
   logic               w_hs;
   logic               w_br_ok;
   logic               w_br_bad;
   logic               w_resp_take;
   logic               w_old_inflight;
   logic [ADDR_W-3:0]  w_idx;

   shift_right_2 #(.ADDR_W(ADDR_W)) u_idx (
      .i_addr (r_pc),
      .o_idx  (w_idx)
   );

   // r_live holds the request off until the first edge after reset release;
   // a pending squash blocks it until the stale response has drained.
   assign w_req_valid = r_live && (r_state == ST_REQ) && !r_squash;
   assign w_hs        = w_req_valid && mem.mem_req_ready;
   assign w_br_ok     = br_taken && (br_target[1:0] == 2'b00) && (r_state != ST_FAULT);
   assign w_br_bad    = br_taken && (br_target[1:0] != 2'b00) && (r_state != ST_FAULT);
   assign w_resp_take = (r_state == ST_WAIT) && mem.mem_resp_valid && !br_taken;

   // A request to the old pc is still owed a response after this edge.
   assign w_old_inflight = ((r_state == ST_WAIT) && !mem.mem_resp_valid)
                        || ((r_state == ST_REQ) && r_squash && !mem.mem_resp_valid)
                        || w_hs;

   assign mem.mem_req_valid = w_req_valid;
   assign mem.mem_req_idx   = w_idx;

   assign instr_valid = w_resp_take || ((r_state == ST_HOLD) && !br_taken);
   assign instr       = w_resp_take ? mem.mem_resp_data : r_instr;
   assign instr_pc    = w_resp_take ? r_pc : r_instr_pc;
   assign misalign    = r_misalign;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_REQ;
         r_pc       <= RESET_PC;
         r_squash   <= 1'b0;
         r_live     <= 1'b0;
         r_misalign <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            ST_REQ: begin
               if (r_squash && mem.mem_resp_valid)
                  r_squash <= 1'b0;
               if (w_hs)
                  r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_resp_take) begin
                  if (!stall) begin
                     r_pc    <= r_pc + ADDR_W'(PC_INC);
                     r_state <= ST_REQ;
                  end else begin
                     r_instr    <= mem.mem_resp_data;
                     r_instr_pc <= r_pc;
                     r_state    <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  r_pc    <= r_pc + ADDR_W'(PC_INC);
                  r_state <= ST_REQ;
               end
            end
            ST_FAULT: ;
         endcase
         // Redirects override whatever the state machine decided above.
         if (w_br_bad) begin
            r_misalign <= 1'b1;
            r_state    <= ST_FAULT;
         end else if (w_br_ok) begin
            r_pc     <= br_target;
            r_state  <= ST_REQ;
            r_squash <= w_old_inflight;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus a randomized run scored against a transaction-level fetch model.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam int ADDR_W = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall;
   logic        br_taken;
   logic [63:0] br_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        misalign;

   int n_pass  = 0;
   int n_total = 0;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

   instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .mem         (mem_bus),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [61:0] idx);
      return idx[31:0] ^ idx[61:30] ^ 32'hC0DE_0001;
   endfunction

   task automatic drive_idle();
      stall = 1'b0;
      br_taken = 1'b0;
      br_target = '0;
      mem_bus.mem_req_ready = 1'b0;
      mem_bus.mem_resp_valid = 1'b0;
      mem_bus.mem_resp_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      drive_idle();
      #2 reset = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else n_pass++;
      n_total++; if (misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign); else n_pass++;
      n_total++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else n_pass++;
      n_total++; if (instr_pc !== 64'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL rel_req_before_edge: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1) $display("FAIL rel_req_after_edge: got %b want 1", mem_bus.mem_req_valid); else n_pass++;
      n_total++; if (mem_bus.mem_req_idx !== 62'h0) $display("FAIL rel_req_idx: got %h want 0", mem_bus.mem_req_idx); else n_pass++;
   endtask

   task automatic test_sequence();
      logic [61:0] exp_idx;
      do_reset();
      mem_bus.mem_req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_idx = 62'(k / 2);
         @(negedge clk);
         mem_bus.mem_resp_valid = (k % 2 == 1);
         mem_bus.mem_resp_data = mem_word(exp_idx);
         #1;
         if (k % 2 == 0) begin
            n_total++; if (mem_bus.mem_req_valid !== 1'b1) $display("FAIL seq_req_valid: got %b want 1", mem_bus.mem_req_valid); else n_pass++;
            n_total++; if (mem_bus.mem_req_idx !== exp_idx) $display("FAIL seq_req_idx: got %h want %h", mem_bus.mem_req_idx, exp_idx); else n_pass++;
            n_total++; if (instr_valid !== 1'b0) $display("FAIL seq_idle_valid: got %b want 0", instr_valid); else n_pass++;
         end else begin
            n_total++; if (instr_valid !== 1'b1) $display("FAIL seq_instr_valid: got %b want 1", instr_valid); else n_pass++;
            n_total++; if (instr_pc !== {exp_idx, 2'b00}) $display("FAIL seq_instr_pc: got %h want %h", instr_pc, {exp_idx, 2'b00}); else n_pass++;
            n_total++; if (instr !== mem_word(exp_idx)) $display("FAIL seq_instr: got %h want %h", instr, mem_word(exp_idx)); else n_pass++;
         end
      end
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk); #1;
      n_total++; if (mem_bus.mem_req_idx !== 62'h0) $display("FAIL stall_req_idx0: got %h want 0", mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h0);
      stall = 1'b1;
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0) $display("FAIL stall_first: got valid=%b pc=%h want valid=1 pc=0", instr_valid, instr_pc); else n_pass++;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         mem_bus.mem_resp_valid = (j == 1);
         mem_bus.mem_resp_data = 32'hDEAD_BEEF;
         #1;
         n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_hold_valid: got %b want 1", instr_valid); else n_pass++;
         n_total++; if (instr !== mem_word(62'h0)) $display("FAIL stall_hold_instr: got %h want %h", instr, mem_word(62'h0)); else n_pass++;
         n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL stall_hold_req: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      end
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      stall = 1'b0;
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr !== mem_word(62'h0)) $display("FAIL stall_release: got valid=%b instr=%h want valid=1 instr=%h", instr_valid, instr, mem_word(62'h0)); else n_pass++;
      n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL stall_release_req: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      @(negedge clk); #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h1) $display("FAIL stall_next_req: got valid=%b idx=%h want valid=1 idx=1", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h1);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h4) $display("FAIL stall_next_pc: got valid=%b pc=%h want valid=1 pc=4", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
   endtask

   task automatic test_branch();
      do_reset();
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk); #1;
      n_total++; if (mem_bus.mem_req_idx !== 62'h0) $display("FAIL br_req_idx0: got %h want 0", mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      br_taken = 1'b1;
      br_target = 64'h100;
      #1;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL br_wait_valid: got %b want 0", instr_valid); else n_pass++;
      @(negedge clk);
      br_taken = 1'b0;
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h0);
      #1;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL br_squash_valid: got %b want 0", instr_valid); else n_pass++;
      n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL br_squash_req: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h40) $display("FAIL br_new_req: got valid=%b idx=%h want valid=1 idx=40", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h40);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h100) $display("FAIL br_target_pc: got valid=%b pc=%h want valid=1 pc=100", instr_valid, instr_pc); else n_pass++;
      n_total++; if (instr !== mem_word(62'h40)) $display("FAIL br_target_instr: got %h want %h", instr, mem_word(62'h40)); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_idx !== 62'h41) $display("FAIL br_seq_idx: got %h want 41", mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h41);
      br_taken = 1'b1;
      br_target = 64'h200;
      #1;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL br_priority_valid: got %b want 0", instr_valid); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h80) $display("FAIL br_priority_req: got valid=%b idx=%h want valid=1 idx=80", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h80);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h200) $display("FAIL br_priority_pc: got valid=%b pc=%h want valid=1 pc=200", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
   endtask

   task automatic test_misalign();
      do_reset();
      @(negedge clk);
      br_taken = 1'b1;
      br_target = 64'h102;
      #1;
      n_total++; if (misalign !== 1'b0) $display("FAIL mis_before_edge: got %b want 0", misalign); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         br_taken = (j == 1);
         br_target = 64'h100;
         mem_bus.mem_req_ready = 1'b1;
         mem_bus.mem_resp_valid = (j == 2);
         mem_bus.mem_resp_data = mem_word(62'h0);
         #1;
         n_total++; if (misalign !== 1'b1) $display("FAIL mis_sticky: got %b want 1", misalign); else n_pass++;
         n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL mis_req: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
         n_total++; if (instr_valid !== 1'b0) $display("FAIL mis_instr_valid: got %b want 0", instr_valid); else n_pass++;
      end
      @(negedge clk);
      drive_idle();
      reset = 1'b0;
      #1;
      n_total++; if (misalign !== 1'b0) $display("FAIL mis_reset_clear: got %b want 0", misalign); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h0) $display("FAIL mis_recover_req: got valid=%b idx=%h want valid=1 idx=0", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [61:0] top_idx;
      top_idx = '1;
      do_reset();
      @(negedge clk);
      br_taken = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFFC;
      @(negedge clk);
      br_taken = 1'b0;
      mem_bus.mem_req_ready = 1'b1;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== top_idx) $display("FAIL wrap_top_req: got valid=%b idx=%h want valid=1 idx=%h", mem_bus.mem_req_valid, mem_bus.mem_req_idx, top_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(top_idx);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_top_pc: got valid=%b pc=%h want valid=1 pc=fffffffffffffffc", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h0) $display("FAIL wrap_req_idx: got valid=%b idx=%h want valid=1 idx=0", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h0);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0) $display("FAIL wrap_instr_pc: got valid=%b pc=%h want valid=1 pc=0", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_bus.mem_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h0);
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h1);
      stall = 1'b1;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h4) $display("FAIL mid_hold: got valid=%b pc=%h want valid=1 pc=4", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      stall = 1'b0;
      @(negedge clk); #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h2) $display("FAIL mid_req2: got valid=%b idx=%h want valid=1 idx=2", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", instr_valid); else n_pass++;
      n_total++; if (instr !== 32'h0) $display("FAIL mid_rst_instr: got %h want 0", instr); else n_pass++;
      n_total++; if (instr_pc !== 64'h0) $display("FAIL mid_rst_instr_pc: got %h want 0", instr_pc); else n_pass++;
      n_total++; if (mem_bus.mem_req_valid !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", mem_bus.mem_req_valid); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h2);
      #1;
      n_total++; if (instr_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) $display("FAIL mid_stale_resp: got valid=%b req=%b want 0 0", instr_valid, mem_bus.mem_req_valid); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
      #1;
      n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== 62'h0) $display("FAIL mid_first_req: got valid=%b idx=%h want valid=1 idx=0", mem_bus.mem_req_valid, mem_bus.mem_req_idx); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_data = mem_word(62'h0);
      #1;
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== mem_word(62'h0)) $display("FAIL mid_first_instr: got valid=%b pc=%h instr=%h want valid=1 pc=0 instr=%h", instr_valid, instr_pc, instr, mem_word(62'h0)); else n_pass++;
      @(negedge clk);
      mem_bus.mem_resp_valid = 1'b0;
   endtask

   // Model: the next instruction to hand over sits at model_pc; delivery advances it by 4,
   // a redirect replaces it. Memory answers each accepted request once, 1-3 cycles later.
   task automatic test_random();
      logic [63:0] model_pc;
      logic [61:0] pend_idx;
      logic [61:0] prev_idx;
      bit          pending;
      bit          prev_wait;
      int          lat;
      int          delivered;
      do_reset();
      model_pc = 64'h0;
      pend_idx = '0;
      prev_idx = '0;
      pending = 1'b0;
      prev_wait = 1'b0;
      lat = 0;
      delivered = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         mem_bus.mem_resp_valid = 1'b0;
         if (pending) begin
            if (lat == 0) begin
               mem_bus.mem_resp_valid = 1'b1;
               mem_bus.mem_resp_data = mem_word(pend_idx);
               pending = 1'b0;
            end else begin
               lat--;
            end
         end
         stall = ($urandom_range(0, 99) < 30);
         mem_bus.mem_req_ready = ($urandom_range(0, 99) < 70);
         br_taken = ($urandom_range(0, 99) < 5);
         br_target = {$urandom, $urandom} & ~64'h3;
         #1;
         if (prev_wait) begin
            n_total++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_idx !== prev_idx) $display("FAIL rnd_req_stable: got valid=%b idx=%h want valid=1 idx=%h", mem_bus.mem_req_valid, mem_bus.mem_req_idx, prev_idx); else n_pass++;
         end
         if (instr_valid === 1'b1) begin
            n_total++; if (instr_pc !== model_pc) $display("FAIL rnd_instr_pc: got %h want %h", instr_pc, model_pc); else n_pass++;
            n_total++; if (instr !== mem_word(model_pc[63:2])) $display("FAIL rnd_instr: got %h want %h", instr, mem_word(model_pc[63:2])); else n_pass++;
         end
         n_total++; if (misalign !== 1'b0) $display("FAIL rnd_misalign: got %b want 0", misalign); else n_pass++;
         if (mem_bus.mem_req_valid === 1'b1 && mem_bus.mem_req_ready) begin
            n_total++; if (pending) $display("FAIL rnd_outstanding: got 2 want 1"); else n_pass++;
            n_total++; if (mem_bus.mem_req_idx !== model_pc[63:2]) $display("FAIL rnd_req_idx: got %h want %h", mem_bus.mem_req_idx, model_pc[63:2]); else n_pass++;
            pending = 1'b1;
            pend_idx = mem_bus.mem_req_idx;
            lat = $urandom_range(0, 2);
         end
         prev_wait = (mem_bus.mem_req_valid === 1'b1) && !mem_bus.mem_req_ready && !br_taken;
         prev_idx = mem_bus.mem_req_idx;
         if (br_taken) begin
            model_pc = br_target;
         end else if (instr_valid === 1'b1 && !stall) begin
            model_pc = model_pc + 64'd4;
            delivered++;
         end
      end
      n_total++; if (delivered < 50) $display("FAIL rnd_progress: got %0d want >=50", delivered); else n_pass++;
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_branch();
      test_misalign();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
